ps2_command_encoder: RTL and testbench
======================================

# ps2_command_encoder

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and turns them into the 3-bit command code that the game controller consumes on its `keyboard_signal` input. Arrow-key and space make codes become single-cycle command pulses, and break codes are swallowed. The block sits between the board's PS/2 connector and the game controller, and it is the only producer of game commands.

## Interface
- `FILTER_LEN`, default 8: number of consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a filtered falling edge before a partial frame is abandoned.
- `clk` input 1: system clock, the single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `keyboard_signal` output 3: command code.
  - 000 idle.
  - 100 down.
  - 101 left.
  - 110 right.
  - 111 rotate.
- `scan_code` output 8: last correctly received byte.
- `frame_err` output 1: one-cycle pulse on a start, parity or stop error, or on a timeout.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through 2 flops.
- **Clock filter:** the synchronised clock feeds a `FILTER_LEN`-bit shift register.
  - The filtered level becomes 1 (or 0) only when all bits are 1 (or all 0); otherwise it holds.
  - A filtered 1→0 transition is a "bit edge". The synchronised data is sampled in the same cycle.
- **Frame receiver:** an 11-bit frame in this order:
  - start bit, must be 0;
  - 8 data bits, LSB first;
  - odd parity bit;
  - stop bit, must be 1.
- **Bit counter:** 4 bits, range 0..10, cleared at frame end.
  - Good frame: drives `byte_valid` for one cycle and updates `scan_code`.
  - Bad frame: pulses `frame_err`; `scan_code` is unchanged.
- **Timeout:** while the bit counter is nonzero, a timeout counter increments every cycle and clears on each bit edge.
  - On reaching `TIMEOUT_CYCLES` the frame is discarded, the bit counter clears and `frame_err` pulses.
- **Decoder FSM** (states IDLE, EXT, BRK, EXT_BRK), acting on each `byte_valid`:
  - IDLE:
    - 0xE0 → EXT.
    - 0xF0 → BRK.
    - 0x29 (space) → emit rotate, stay IDLE.
    - Any other byte → stay IDLE, no emit.
  - EXT:
    - 0xF0 → EXT_BRK.
    - 0x72 → emit down.
    - 0x6B → emit left.
    - 0x74 → emit right.
    - 0x75 → emit rotate.
    - All EXT transitions except 0xF0 go to IDLE. Unlisted bytes emit nothing.
  - BRK and EXT_BRK: any byte → IDLE, no emit.
  - `frame_err` forces the FSM to IDLE.
- **Emit:** `keyboard_signal` carries the code for exactly one cycle, then returns to 000. Keyboard typematic repeat produces repeated make codes, and therefore repeated pulses.

## Timing
- **Reset values:**
  - `keyboard_signal` = 000, `scan_code` = 0x00, `frame_err` = 0.
  - FSM in IDLE; bit and timeout counters at 0.
  - Filter register and filtered level all 1.
- **Reset mid-frame:** the partial frame is discarded with no `frame_err`.
- **Latency:**
  - Raw `ps2_clk` fall to bit edge: 2 + `FILTER_LEN` cycles.
  - Stop-bit edge at cycle N: `scan_code` / `frame_err` update at N+1, `keyboard_signal` pulse at N+2.
- **Pulse spacing:** consecutive pulses are at least one full frame apart, i.e. more than 500 `clk` cycles at any legal PS/2 rate. They never merge.
- **Simultaneous events:** timeout and bit edge in the same cycle — the bit edge wins and the timeout counter clears.
- **Width rules:**
  - Timeout counter width is $clog2(`TIMEOUT_CYCLES`+1).
  - Parity = XOR of the 8 data bits and the parity bit, which must equal 1.

## Configuration
- Macro: `PS2_PARITY_CHECK_EN`.
- Defined: a parity mismatch rejects the frame and pulses `frame_err`.
- Undefined: the parity bit is sampled and ignored. Only start and stop bits and the timeout can raise `frame_err`.

## Structure
- **Shared package `ps2_pkg`:**
  - Command codes: CMD_IDLE, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_ROTATE.
  - Scan-code constants: 0xE0, 0xF0, 0x72, 0x6B, 0x74, 0x75, 0x29.
  - Decoder state typedef.
- **Sub-module `ps2_frame_rx`:** synchronisers, filter, bit counter, timeout, parity.
  - Outputs: `byte_valid`, `byte_data`, `frame_err`.
  - The top level holds the decoder FSM and the output register.

## Test plan
- **Extended down:** frames 0xE0, 0x72 at 12.5 kHz → exactly one `keyboard_signal` = 100 pulse, N+2 after the 0x72 stop edge; `scan_code` = 0x72.
- **Break swallowed:** 0xE0, 0xF0, 0x6B, then 0xF0, 0x29 → no pulse; FSM in IDLE afterwards.
- **Space:** 0x29 → one 111 pulse. Then 0xE0, 0x74 → one 110 pulse.
- **Parity error** (with `PS2_PARITY_CHECK_EN`): bad-parity 0x75 after 0xE0 → `frame_err` pulse, no emit. A following 0xE0, 0x75 → 111.
- **Timeout:** stop clocking after 5 bits for `TIMEOUT_CYCLES` → `frame_err` pulse. A following clean 0x29 → 111.
- **Glitch and reset:** a 3-cycle low glitch on `ps2_clk` with `FILTER_LEN` = 8 → no bit edge. Assert `rst` mid-frame → all outputs at reset values and no emit; the next frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: command codes, scan-code constants and decoder state shared by the
// PS/2 receiver and the command encoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE   = 3'b000,
        CMD_DOWN   = 3'b100,
        CMD_LEFT   = 3'b101,
        CMD_RIGHT  = 3'b110,
        CMD_ROTATE = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Bit-counter values of the last data bit and of the stop bit.
    localparam logic [3:0] DATA_LAST  = 4'd8;
    localparam logic [3:0] FRAME_LAST = 4'd10;

    function automatic cmd_e ext_cmd(input logic [7:0] code);
        return code == SC_DOWN  ? CMD_DOWN  :
               code == SC_LEFT  ? CMD_LEFT  :
               code == SC_RIGHT ? CMD_RIGHT :
               code == SC_UP    ? CMD_ROTATE : CMD_IDLE;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the raw PS/2 pins and assembles 11-bit frames.
// PS2_PARITY_CHECK_EN enables rejection of frames with bad odd parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic [FILTER_LEN-1:0] flt_q;
    logic                  lvl_q;
    logic [3:0]            cnt_q;
    logic [7:0]            sh_q;
    logic [TW-1:0]         to_q;
    logic                  byte_valid_q;
    logic                  frame_err_q;
    logic [7:0]            byte_q;
    logic                  dat;
    logic                  bit_edge;
    logic                  timeout;
    logic                  par_ok;

    assign dat      = dat_sync_q[1];
    assign bit_edge = lvl_q && flt_q == '0;
    assign timeout  = cnt_q != 4'd0 && !bit_edge && to_q == TW'(TIMEOUT_CYCLES);

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (bit_edge && cnt_q == DATA_LAST + 4'd1)
            par_q <= dat;
    end

    assign par_ok = ^{sh_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            flt_q        <= '1;
            lvl_q        <= 1'b1;
            cnt_q        <= 4'd0;
            sh_q         <= 8'h00;
            to_q         <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_data};
            flt_q        <= {flt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            lvl_q        <= (&flt_q) | (lvl_q & (|flt_q));
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            to_q         <= (cnt_q == 4'd0 || bit_edge || timeout) ? '0 : to_q + 1'b1;
            if (bit_edge) begin
                if (cnt_q == 4'd0) begin
                    cnt_q       <= dat ? 4'd0 : 4'd1;
                    frame_err_q <= dat;
                end else if (cnt_q == FRAME_LAST) begin
                    cnt_q <= 4'd0;
                    if (dat && par_ok) begin
                        byte_valid_q <= 1'b1;
                        byte_q       <= sh_q;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q <= DATA_LAST)
                        sh_q <= {dat, sh_q[7:1]};
                end
            end else if (timeout) begin
                cnt_q       <= 4'd0;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_command_encoder.sv
// ps2_command_encoder: turns PS/2 make codes into one-cycle game command pulses.
// PS2_PARITY_CHECK_EN (in ps2_frame_rx) enables parity rejection.
module ps2_command_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] keyboard_signal,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_err;
    dec_state_e state_q;
    logic [2:0] kbd_q;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (rx_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kbd_q   <= CMD_IDLE;
        end else begin
            kbd_q <= CMD_IDLE;
            if (rx_err) begin
                state_q <= ST_IDLE;
            end else if (byte_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= byte_data == SC_EXT ? ST_EXT :
                                   byte_data == SC_BRK ? ST_BRK : ST_IDLE;
                        kbd_q   <= byte_data == SC_SPACE ? CMD_ROTATE : CMD_IDLE;
                    end
                    ST_EXT: begin
                        state_q <= byte_data == SC_BRK ? ST_EXT_BRK : ST_IDLE;
                        kbd_q   <= ext_cmd(byte_data);
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign keyboard_signal = kbd_q;
    assign scan_code       = byte_data;
    assign frame_err       = rx_err;

endmodule

// File: tb/tb_ps2_command_encoder.sv
// tb_ps2_command_encoder: directed PS/2 frames with a queue of expected output events.
module tb_ps2_command_encoder;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [2:0] keyboard_signal;
    logic [7:0] scan_code;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic       err;
        logic [2:0] cmd;
        logic [7:0] scan;
        int         at;
    } ev_t;

    ev_t exp_q[$];

    ps2_command_encoder #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keyboard_signal(keyboard_signal),
        .scan_code      (scan_code),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of a frame; for a full frame, queues the expected event
    // right at the stop-bit fall, timed from the raw fall: edge at +2+FL, err +1, pulse +2.
    task automatic send(input logic [7:0] b, input int nbits, input bit badp,
                        input logic [2:0] ecmd, input bit eerr, input logic [7:0] escan);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ badp, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            ticks(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && (ecmd != 3'b000 || eerr))
                exp_q.push_back('{eerr, ecmd, escan, cyc + FL + (eerr ? 3 : 4)});
            ticks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        ticks(4 * HALF);
    endtask

    always @(negedge clk) begin
        if (!rst && (keyboard_signal != 3'b000 || frame_err)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected output: kbd=%b err=%b scan=%h (cycle %0d)",
                         keyboard_signal, frame_err, scan_code, cyc);
            end else begin : pop
                ev_t e;
                e = exp_q.pop_front();
                check("frame_err", frame_err, e.err);
                check("keyboard_signal", keyboard_signal, e.cmd);
                check("scan_code", scan_code, e.scan);
                if (e.at >= 0)
                    check("event_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ticks(3);
        check("reset_kbd", keyboard_signal, 3'b000);
        check("reset_scan", scan_code, 8'h00);
        check("reset_err", frame_err, 1'b0);
        rst = 1'b0;
        ticks(20);
        // extended down
        send(8'hE0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'h72, 11, 0, CMD_DOWN, 0, 8'h72);
        // breaks swallowed
        send(8'hE0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'hF0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'h6B, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'hF0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'h29, 11, 0, CMD_IDLE, 0, 8'h00);
        // space then extended right; the space pulse also proves the FSM sits in IDLE
        send(8'h29, 11, 0, CMD_ROTATE, 0, 8'h29);
        send(8'hE0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'h74, 11, 0, CMD_RIGHT, 0, 8'h74);
        // bad parity on 0x75 after 0xE0
        send(8'hE0, 11, 0, CMD_IDLE, 0, 8'h00);
`ifdef PS2_PARITY_CHECK_EN
        send(8'h75, 11, 1, CMD_IDLE, 1, 8'hE0);
`else
        send(8'h75, 11, 1, CMD_ROTATE, 0, 8'h75);
`endif
        send(8'hE0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'h75, 11, 0, CMD_ROTATE, 0, 8'h75);
        // timeout after 5 bits, then a clean space
        send(8'h29, 5, 0, CMD_IDLE, 0, 8'h00);
        exp_q.push_back('{1'b1, CMD_IDLE, 8'h75, -1});
        ticks(TO + 100);
        check("timeout_drained", exp_q.size(), 0);
        send(8'h29, 11, 0, CMD_ROTATE, 0, 8'h29);
        // 3-cycle glitch must not produce a bit edge (a false edge would raise frame_err)
        ps2_clk = 1'b0;
        ticks(3);
        ps2_clk = 1'b1;
        ticks(50);
        // reset mid-frame
        send(8'h72, 5, 0, CMD_IDLE, 0, 8'h00);
        rst = 1'b1;
        ticks(2);
        check("midrst_kbd", keyboard_signal, 3'b000);
        check("midrst_scan", scan_code, 8'h00);
        check("midrst_err", frame_err, 1'b0);
        rst = 1'b0;
        ticks(20);
        send(8'hE0, 11, 0, CMD_IDLE, 0, 8'h00);
        send(8'h72, 11, 0, CMD_DOWN, 0, 8'h72);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            ticks(1);
        check("queue_empty", exp_q.size(), 0);
        check("final_scan", scan_code, 8'h72);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
